// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the instruction buffer: default depth, fetch lane layout and the
// wrap-bit queue pointer type.
package inst_buffer_pkg;

  localparam int unsigned IbSz       = 16;
  localparam int unsigned IbIdxBits  = $clog2(IbSz);
  localparam int unsigned FetchLanes = 4;
  localparam int unsigned GhrBits    = 8;

  typedef struct packed {
    logic               valid;
    logic [31:0]        pc;
    logic [31:0]        inst;
    logic               is_branch;
    logic               bp_pred_taken;
    logic [31:0]        bp_pred_target;
    logic [GhrBits-1:0] bp_ghr_snapshot;
  } fetch_packet_t;

  // Index bits plus one wrap bit: equal index with differing wrap bits means full.
  typedef logic [IbIdxBits:0] ib_ptr_t;

endpackage

// File: rtl/ib_compact.sv
// Packs the valid fetch lanes into the low output slots in ascending lane order and reports
// how many there are (a running prefix sum of the valid bits).
module ib_compact
  import inst_buffer_pkg::*;
(
  input  fetch_packet_t [FetchLanes-1:0] lanes_in,
  output fetch_packet_t [FetchLanes-1:0] lanes_out,
  output logic [2:0]                     enq_count
);

  always_comb begin
    logic [2:0] pos;
    pos       = '0;
    lanes_out = '0;
    for (int i = 0; i < FetchLanes; i++) begin
      if (lanes_in[i].valid) begin
        lanes_out[pos[1:0]] = lanes_in[i];
        pos = pos + 3'd1;
      end
    end
    enq_count = pos;
  end

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and dispatch. Define IB_STATS_EN to add the
// enqueue / full-cycle / flush statistics counters.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned IB_DEPTH   = IbSz,
  parameter int unsigned DISP_WIDTH = 3
) (
  input  logic                               clock,
  input  logic                               reset,
  input  fetch_packet_t [FetchLanes-1:0]     fetch_packet,
  input  logic                               flush,
  output logic [$clog2(IB_DEPTH):0]          ib_free_slots,
  output fetch_packet_t [DISP_WIDTH-1:0]     dispatch_packet,
  input  logic [$clog2(DISP_WIDTH+1)-1:0]    dispatch_count,
  output logic [$clog2(IB_DEPTH):0]          ib_count
`ifdef IB_STATS_EN
  ,
  output logic [31:0]                        stat_enq_total,
  output logic [31:0]                        stat_full_cycles,
  output logic [31:0]                        stat_flushes
`endif
);

  localparam int unsigned IdxBits = $clog2(IB_DEPTH);
  localparam int unsigned CntW    = IdxBits + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(IB_DEPTH);
  localparam logic [CntW-1:0] DispC  = CntW'(DISP_WIDTH);

  typedef logic [IdxBits:0] ptr_t;

  ptr_t            head_q, head_d;
  ptr_t            tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] free_q;
  logic [CntW-1:0] avail, deq, space, enq_raw, enq;

  fetch_packet_t [FetchLanes-1:0] lanes;
  logic [2:0]                     lane_count;
  fetch_packet_t                  mem [IB_DEPTH];

  ib_compact u_compact (
    .lanes_in  (fetch_packet),
    .lanes_out (lanes),
    .enq_count (lane_count)
  );

  always_comb begin
    avail   = (count_q < DispC) ? count_q : DispC;
    deq     = (CntW'(dispatch_count) > avail) ? avail : CntW'(dispatch_count);
    // Slots popped this cycle are reusable by this cycle's enqueue.
    space   = DepthC - count_q + deq;
    enq_raw = CntW'(lane_count);
    enq     = (enq_raw > space) ? space : enq_raw;
    if (flush) begin
      enq    = '0;
      deq    = '0;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + ptr_t'(deq);
      tail_d  = tail_q + ptr_t'(enq);
      count_d = count_q + enq - deq;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= DepthC;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      free_q  <= DepthC - count_d;
    end
  end

  // Entry storage needs no reset; occupancy alone qualifies what dispatch sees.
  always_ff @(posedge clock) begin
    for (int k = 0; k < FetchLanes; k++) begin
      if (CntW'(k) < enq) begin
        mem[tail_q[IdxBits-1:0] + IdxBits'(k)] <= lanes[k];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DISP_WIDTH; i++) begin
      dispatch_packet[i]       = mem[head_q[IdxBits-1:0] + IdxBits'(i)];
      dispatch_packet[i].valid = count_q > CntW'(i);
    end
  end

  assign ib_count      = count_q;
  assign ib_free_slots = free_q;

`ifdef IB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_enq_total   <= '0;
      stat_full_cycles <= '0;
      stat_flushes     <= '0;
    end else begin
      stat_enq_total <= stat_enq_total + 32'(enq);
      if (free_q < CntW'(4)) begin
        stat_full_cycles <= stat_full_cycles + 32'd1;
      end
      if (flush) begin
        stat_flushes <= stat_flushes + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer: compaction, wrap ordering, overflow drop,
// dequeue clamp, flush, asynchronous reset and branch metadata pass-through.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 flush;
  fetch_packet_t [3:0]  fetch_packet;
  fetch_packet_t [2:0]  dispatch_packet;
  logic [1:0]           dispatch_count;
  logic [4:0]           ib_free_slots;
  logic [4:0]           ib_count;

  int tests = 0;
  int fails = 0;

  inst_buffer #(
    .IB_DEPTH   (16),
    .DISP_WIDTH (3)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .fetch_packet    (fetch_packet),
    .flush           (flush),
    .ib_free_slots   (ib_free_slots),
    .dispatch_packet (dispatch_packet),
    .dispatch_count  (dispatch_count),
    .ib_count        (ib_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    fetch_packet   = '0;
    flush          = 1'b0;
    dispatch_count = 2'd0;
  endtask

  task automatic set_fetch(input logic [3:0] mask, input logic [31:0] pc0);
    for (int i = 0; i < 4; i++) begin
      fetch_packet[i]       = '0;
      fetch_packet[i].valid = mask[i];
      fetch_packet[i].pc    = pc0 + 32'(4 * i);
      fetch_packet[i].inst  = 32'h0000_0013 + 32'(i);
    end
  endtask

  task automatic push(input logic [3:0] mask, input logic [31:0] pc0);
    set_fetch(mask, pc0);
    step();
    idle();
  endtask

  task automatic pop(input logic [1:0] n);
    dispatch_count = n;
    step();
    idle();
  endtask

  function automatic logic [2:0] valids();
    return {dispatch_packet[2].valid, dispatch_packet[1].valid, dispatch_packet[0].valid};
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_count", ib_count, 0);
    check("rst_free", ib_free_slots, 16);
    check("rst_valid", valids(), 3'b000);

    // Dense enqueue, visible one cycle later.
    push(4'b1111, 32'h0);
    check("dense_count", ib_count, 4);
    check("dense_free", ib_free_slots, 12);
    check("dense_pc0", dispatch_packet[0].pc, 32'h0);
    check("dense_pc1", dispatch_packet[1].pc, 32'h4);
    check("dense_pc2", dispatch_packet[2].pc, 32'h8);
    check("dense_valid", valids(), 3'b111);

    flush = 1'b1;
    step();
    idle();
    check("flush1_count", ib_count, 0);

    // Sparse lanes 1 and 2 stored contiguously.
    push(4'b0110, 32'h0);
    check("sparse_pc0", dispatch_packet[0].pc, 32'h4);
    check("sparse_pc1", dispatch_packet[1].pc, 32'h8);
    check("sparse_valid", valids(), 3'b011);
    check("sparse_count", ib_count, 2);

    // Asking for 3 with only 2 present pops just 2.
    pop(2'd3);
    check("clamp_count", ib_count, 0);
    check("clamp_free", ib_free_slots, 16);

    // Move head/tail to index 15, then fill so the tail wraps.
    flush = 1'b1;
    step();
    idle();
    for (int c = 0; c < 3; c++) push(4'b1111, 32'h100 + 32'(16 * c));
    push(4'b0111, 32'h130);
    check("pre_count", ib_count, 15);
    repeat (5) pop(2'd3);
    check("drain_count", ib_count, 0);
    for (int c = 0; c < 4; c++) push(4'b1111, 32'h200 + 32'(16 * c));
    check("full_count", ib_count, 16);
    check("full_free", ib_free_slots, 0);
    check("full_pc0", dispatch_packet[0].pc, 32'h200);

    // Overflow lanes are dropped.
    push(4'b1111, 32'h900);
    check("ovf_count", ib_count, 16);
    check("ovf_pc0", dispatch_packet[0].pc, 32'h200);

    // Pop 3 while enqueuing 3 at indices 15, 0, 1.
    set_fetch(4'b0111, 32'h240);
    dispatch_count = 2'd3;
    step();
    idle();
    check("swap_count", ib_count, 16);
    check("swap_free", ib_free_slots, 0);
    check("swap_pc0", dispatch_packet[0].pc, 32'h20C);

    pop(2'd3);
    check("pop3_count", ib_count, 13);
    check("pop3_free", ib_free_slots, 3);

    for (int k = 0; k < 13; k++) begin
      check($sformatf("order_%0d", k), dispatch_packet[0].pc, 32'h218 + 32'(4 * k));
      pop(2'd1);
    end
    check("order_empty", ib_count, 0);

    // Flush beats concurrent enqueue and dequeue.
    push(4'b1111, 32'h300);
    push(4'b1111, 32'h310);
    push(4'b0011, 32'h320);
    check("pf_count", ib_count, 10);
    set_fetch(4'b1111, 32'h400);
    dispatch_count = 2'd2;
    flush = 1'b1;
    step();
    idle();
    check("flush_count", ib_count, 0);
    check("flush_free", ib_free_slots, 16);
    check("flush_valid", valids(), 3'b000);
    step();
    check("flush_after", ib_count, 0);

    // Asynchronous reset between edges.
    push(4'b1111, 32'h500);
    push(4'b0111, 32'h510);
    check("ar_pre", ib_count, 7);
    #2 reset = 1'b1;
    #1;
    check("ar_count", ib_count, 0);
    check("ar_free", ib_free_slots, 16);
    check("ar_valid", valids(), 3'b000);
    #1 reset = 1'b0;
    step();

    // Branch metadata passes through untouched.
    fetch_packet = '0;
    fetch_packet[0].valid           = 1'b1;
    fetch_packet[0].pc              = 32'h40;
    fetch_packet[0].is_branch       = 1'b1;
    fetch_packet[0].bp_pred_taken   = 1'b1;
    fetch_packet[0].bp_pred_target  = 32'h80;
    fetch_packet[0].bp_ghr_snapshot = 8'h5A;
    step();
    idle();
    check("br_count", ib_count, 1);
    check("br_pc", dispatch_packet[0].pc, 32'h40);
    check("br_is", dispatch_packet[0].is_branch, 1);
    check("br_taken", dispatch_packet[0].bp_pred_taken, 1);
    check("br_target", dispatch_packet[0].bp_pred_target, 32'h80);
    check("br_ghr", dispatch_packet[0].bp_ghr_snapshot, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
